video_frame_monitor: RTL and testbench

//  Parametrised, synthesisable video stream monitor for the System86 video output
//  (or any RGB + sync/blank source), sampled on the system clock with a pixel enable.

---
 rtl/video_frame_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_video_frame_monitor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_monitor.sv
// Video stream monitor: per-frame line/frame geometry, lock detection and CRC-16-CCITT
// of active pixels. Define VIDEO_FRAME_MONITOR_CRC_CHECK_EN for the sticky CRC compare ports.
module video_frame_monitor #(
    parameter int COMPONENT_DEPTH = 4,
    parameter int COUNT_WIDTH     = 12,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_ce,
    input  logic [COMPONENT_DEPTH-1:0] vid_red,
    input  logic [COMPONENT_DEPTH-1:0] vid_green,
    input  logic [COMPONENT_DEPTH-1:0] vid_blue,
    input  logic                       vid_hsync_n,
    input  logic                       vid_vsync_n,
    input  logic                       vid_hblank_n,
    input  logic                       vid_vblank_n,
    output logic                       frame_done,
    output logic [COUNT_WIDTH-1:0]     h_total,
    output logic [COUNT_WIDTH-1:0]     v_total,
    output logic [COUNT_WIDTH-1:0]     width,
    output logic [COUNT_WIDTH-1:0]     height,
    output logic                       locked,
    output logic [15:0]                frame_crc,
    output logic [15:0]                frame_count
`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
    ,
    input  logic [15:0]                crc_expected,
    output logic                       crc_mismatch
`endif
);
    localparam int PIX_W = 3 * COMPONENT_DEPTH;
    localparam int LCW   = $clog2(LOCK_FRAMES + 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [LCW-1:0]         LOCK_MAX = LCW'(LOCK_FRAMES);
    localparam logic [LCW-1:0]         LOCK_MIN = LCW'(LOCK_FRAMES - 1);

    typedef enum logic {WAIT_SYNC, MEASURE} state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic [PIX_W-1:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    state_t                 state_q, state_d;
    logic                   hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [COUNT_WIDTH-1:0] h_cnt_q, h_cnt_d, h_last_q, h_last_d;
    logic [COUNT_WIDTH-1:0] v_cnt_q, v_cnt_d, wid_cnt_q, wid_cnt_d, hgt_cnt_q, hgt_cnt_d;
    logic                   wid_open_q, wid_open_d, wid_done_q, wid_done_d;
    logic                   line_act_q, line_act_d;
    logic [15:0]            crc_q, crc_d;
    logic                   frame_done_q, frame_done_d;
    logic [COUNT_WIDTH-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [COUNT_WIDTH-1:0] width_q, width_d, height_q, height_d;
    logic                   locked_q, locked_d, have_prev_q, have_prev_d;
    logic [LCW-1:0]         match_cnt_q, match_cnt_d;
    logic [15:0]            frame_crc_q, frame_crc_d, frame_count_q, frame_count_d;
    logic                   hs_fall, vs_fall, act, match;
    logic [PIX_W-1:0]       pix;

    always_comb begin
        hs_fall = pix_ce & hs_prev_q & ~vid_hsync_n;
        vs_fall = pix_ce & vs_prev_q & ~vid_vsync_n;
        act     = pix_ce & vid_hblank_n & vid_vblank_n;
        pix     = {vid_red, vid_green, vid_blue};
        match   = 1'b0;

        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_cnt_d       = h_cnt_q;
        h_last_d      = h_last_q;
        v_cnt_d       = v_cnt_q;
        wid_cnt_d     = wid_cnt_q;
        hgt_cnt_d     = hgt_cnt_q;
        wid_open_d    = wid_open_q;
        wid_done_d    = wid_done_q;
        line_act_d    = line_act_q;
        crc_d         = crc_q;
        frame_done_d  = 1'b0;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        width_d       = width_q;
        height_d      = height_q;
        locked_d      = locked_q;
        have_prev_d   = have_prev_q;
        match_cnt_d   = match_cnt_q;
        frame_crc_d   = frame_crc_q;
        frame_count_d = frame_count_q;

        if (pix_ce) begin
            hs_prev_d = vid_hsync_n;
            vs_prev_d = vid_vsync_n;
            h_cnt_d   = hs_fall ? COUNT_WIDTH'(1) : sat_inc(h_cnt_q);
        end

        // Close the line before the frame so a coincident hsync edge lands in the closing frame.
        if (hs_fall) begin
            h_last_d   = h_cnt_q;
            v_cnt_d    = sat_inc(v_cnt_q);
            line_act_d = 1'b0;
            if (wid_open_q) begin
                wid_open_d = 1'b0;
                wid_done_d = 1'b1;
            end
        end

        if (vs_fall) begin
            state_d = MEASURE;
            if (state_q == MEASURE) begin
                match = have_prev_q &&
                        ({h_last_d, v_cnt_d, wid_cnt_q, hgt_cnt_q} ==
                         {h_total_q, v_total_q, width_q, height_q});
                match_cnt_d   = !match ? '0 :
                                (match_cnt_q == LOCK_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
                locked_d      = match_cnt_d >= LOCK_MIN;
                have_prev_d   = 1'b1;
                h_total_d     = h_last_d;
                v_total_d     = v_cnt_d;
                width_d       = wid_cnt_q;
                height_d      = hgt_cnt_q;
                frame_crc_d   = crc_q;
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
            end
            v_cnt_d    = '0;
            wid_cnt_d  = '0;
            hgt_cnt_d  = '0;
            wid_open_d = 1'b0;
            wid_done_d = 1'b0;
            line_act_d = 1'b0;
            crc_d      = 16'hFFFF;
        end

        // The pixel sampled with an edge belongs to the new line/frame.
        if (act) begin
            crc_d = crc_next(crc_d, pix);
            if (!wid_done_d) begin
                wid_cnt_d  = sat_inc(wid_cnt_d);
                wid_open_d = 1'b1;
            end
            if (!line_act_d) begin
                hgt_cnt_d  = sat_inc(hgt_cnt_d);
                line_act_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_SYNC;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            h_cnt_q       <= '0;
            h_last_q      <= '0;
            v_cnt_q       <= '0;
            wid_cnt_q     <= '0;
            hgt_cnt_q     <= '0;
            wid_open_q    <= 1'b0;
            wid_done_q    <= 1'b0;
            line_act_q    <= 1'b0;
            crc_q         <= 16'hFFFF;
            frame_done_q  <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            width_q       <= '0;
            height_q      <= '0;
            locked_q      <= 1'b0;
            have_prev_q   <= 1'b0;
            match_cnt_q   <= '0;
            frame_crc_q   <= 16'hFFFF;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_cnt_q       <= h_cnt_d;
            h_last_q      <= h_last_d;
            v_cnt_q       <= v_cnt_d;
            wid_cnt_q     <= wid_cnt_d;
            hgt_cnt_q     <= hgt_cnt_d;
            wid_open_q    <= wid_open_d;
            wid_done_q    <= wid_done_d;
            line_act_q    <= line_act_d;
            crc_q         <= crc_d;
            frame_done_q  <= frame_done_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            width_q       <= width_d;
            height_q      <= height_d;
            locked_q      <= locked_d;
            have_prev_q   <= have_prev_d;
            match_cnt_q   <= match_cnt_d;
            frame_crc_q   <= frame_crc_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign width       = width_q;
    assign height      = height_q;
    assign locked      = locked_q;
    assign frame_crc   = frame_crc_q;
    assign frame_count = frame_count_q;

`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
    logic crc_mismatch_q, crc_mismatch_d;

    always_comb begin
        crc_mismatch_d = crc_mismatch_q | (frame_done_q & locked_q & (frame_crc_q != crc_expected));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_mismatch_q <= 1'b0;
        else        crc_mismatch_q <= crc_mismatch_d;
    end

    assign crc_mismatch = crc_mismatch_q;
`endif
endmodule

// File: tb/tb_video_frame_monitor.sv
// Bench for video_frame_monitor: scaled-down System86-like frames with random pixel-enable
// gaps, checked against a frame-level reference model (geometry, lock run length, CRC).
module tb_video_frame_monitor;
    localparam int CD   = 4;
    localparam int CW   = 12;
    localparam int LF   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_ce = 1'b0;
    logic [CD-1:0] vid_red = '0, vid_green = '0, vid_blue = '0;
    logic          vid_hsync_n = 1'b1, vid_vsync_n = 1'b1;
    logic          vid_hblank_n = 1'b0, vid_vblank_n = 1'b0;
    logic          frame_done, locked;
    logic [CW-1:0] h_total, v_total, width, height;
    logic [15:0]   frame_crc, frame_count;
`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
    logic [15:0]   crc_expected = 16'h0000;
    logic          crc_mismatch;
`endif

    video_frame_monitor #(.COMPONENT_DEPTH(CD), .COUNT_WIDTH(CW), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .vid_red(vid_red), .vid_green(vid_green), .vid_blue(vid_blue),
        .vid_hsync_n(vid_hsync_n), .vid_vsync_n(vid_vsync_n),
        .vid_hblank_n(vid_hblank_n), .vid_vblank_n(vid_vblank_n),
        .frame_done(frame_done), .h_total(h_total), .v_total(v_total),
        .width(width), .height(height), .locked(locked),
        .frame_crc(frame_crc), .frame_count(frame_count)
`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
        , .crc_expected(crc_expected), .crc_mismatch(crc_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_pulses = 0;
    int exp_pulses = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

    // Reference model state: previous frame geometry and length of the identical run.
    bit have_prev = 0;
    int prev_h, prev_v, prev_w, prev_ht;
    int run = 0;
    int exp_fc = 0;

    function automatic logic [11:0] pix_val(input int seed, input int x, input int y);
        int v;
        v = seed * 97 + x * 31 + y * 57 + x * y * 13;
        v = v ^ (v >>> 5);
        return v[11:0];
    endfunction

    function automatic logic [11:0] pix_at(input int seed, input int x, input int y,
                                           input int fx, input int fy, input int fb);
        logic [11:0] p;
        p = pix_val(seed, x, y);
        if (x == fx && y == fy) p[fb] = ~p[fb];
        return p;
    endfunction

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        c = c << 1;
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    function automatic logic [15:0] model_crc(input int hx0, input int aw, input int vy0, input int ah,
                                              input int seed, input int fx, input int fy, input int fb);
        logic [15:0] c;
        logic [11:0] p;
        c = 16'hFFFF;
        for (int y = vy0; y < vy0 + ah; y++)
            for (int x = hx0; x < hx0 + aw; x++) begin
                p = pix_at(seed, x, y, fx, fy, fb);
                for (int k = 11; k >= 0; k--) c = crc_bit(c, p[k]);
            end
        return c;
    endfunction

    task automatic smp(input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic [11:0] p, input int gmax);
        int idle;
        idle = $urandom_range(gmax, 0);
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            pix_ce = 1'b0;
            {vid_hsync_n, vid_vsync_n, vid_hblank_n, vid_vblank_n} = 4'($urandom);
            {vid_red, vid_green, vid_blue} = 12'($urandom);
        end
        @(negedge clk);
        pix_ce = 1'b1;
        vid_hsync_n = hs;
        vid_vsync_n = vs;
        vid_hblank_n = hb;
        vid_vblank_n = vb;
        {vid_red, vid_green, vid_blue} = p;
    endtask

    // Frame layout: hsync low for x<3, vsync low for y<3; edge sample (0,0) is issued by the caller.
    task automatic drive_body(input int hlen, input int nlines, input int hx0, input int aw,
                              input int vy0, input int ah, input int seed, input int gmax,
                              input int fx, input int fy, input int fb);
        logic hb, vb;
        logic [11:0] p;
        for (int y = 0; y < nlines; y++)
            for (int x = 0; x < hlen; x++) begin
                if (x == 0 && y == 0) continue;
                hb = (x >= hx0) && (x < hx0 + aw);
                vb = (y >= vy0) && (y < vy0 + ah);
                p = (hb && vb) ? pix_at(seed, x, y, fx, fy, fb) : 12'($urandom);
                smp(x >= 3, y >= 3, hb, vb, p, gmax);
            end
    endtask

    task automatic open_frame(input int gmax);
        smp(1'b1, 1'b1, 1'b0, 1'b0, 12'($urandom), gmax);
        smp(1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom), gmax);
    endtask

    task automatic run_frame(input string nm, input int hlen, input int vlen, input int hx0,
                             input int aw, input int vy0, input int ah, input int seed,
                             input int gmax, input int fx, input int fy, input int fb);
        int eh, ev, ew, eht;
        logic [15:0] ecrc;
        logic elock;
        eh   = (hlen > CMAX) ? CMAX : hlen;
        ev   = vlen;
        ew   = (ah > 0) ? aw : 0;
        eht  = (aw > 0) ? ah : 0;
        ecrc = model_crc(hx0, aw, vy0, ah, seed, fx, fy, fb);
        run  = (have_prev && eh == prev_h && ev == prev_v && ew == prev_w && eht == prev_ht) ? run + 1 : 1;
        elock = (run >= LF);
        have_prev = 1;
        {prev_h, prev_v, prev_w, prev_ht} = {eh, ev, ew, eht};
        exp_fc++;

        drive_body(hlen, vlen, hx0, aw, vy0, ah, seed, gmax, fx, fy, fb);
        n_checks++;
        if (done_pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL %s early_done pulses got %0d exp %0d", nm, done_pulses, exp_pulses);
        end
        smp(1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom), gmax);
        @(negedge clk);
        pix_ce = 1'b0;
        exp_pulses++;
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("FAIL %s frame_done got %b exp 1", nm, frame_done);
        end
        n_checks++;
        if (h_total !== CW'(eh)) begin
            n_fail++; $display("FAIL %s h_total got %0d exp %0d", nm, h_total, eh);
        end
        n_checks++;
        if (v_total !== CW'(ev)) begin
            n_fail++; $display("FAIL %s v_total got %0d exp %0d", nm, v_total, ev);
        end
        n_checks++;
        if (width !== CW'(ew)) begin
            n_fail++; $display("FAIL %s width got %0d exp %0d", nm, width, ew);
        end
        n_checks++;
        if (height !== CW'(eht)) begin
            n_fail++; $display("FAIL %s height got %0d exp %0d", nm, height, eht);
        end
        n_checks++;
        if (frame_crc !== ecrc) begin
            n_fail++; $display("FAIL %s frame_crc got %h exp %h", nm, frame_crc, ecrc);
        end
        n_checks++;
        if (locked !== elock) begin
            n_fail++; $display("FAIL %s locked got %b exp %b", nm, locked, elock);
        end
        n_checks++;
        if (frame_count !== 16'(exp_fc)) begin
            n_fail++; $display("FAIL %s frame_count got %0d exp %0d", nm, frame_count, exp_fc);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL %s done_width got %b exp 0", nm, frame_done);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        n_checks++;
        if ({frame_done, h_total, v_total, width, height, locked, frame_crc, frame_count} !==
            {1'b0, {4{CW'(0)}}, 1'b0, 16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL %s reset outputs got done=%b h=%0d v=%0d w=%0d ht=%0d lk=%b crc=%h fc=%0d exp zeros crc=ffff",
                     nm, frame_done, h_total, v_total, width, height, locked, frame_crc, frame_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
        n_checks++;
        if (crc_mismatch !== 1'b0) begin
            n_fail++; $display("FAIL reset crc_mismatch got %b exp 0", crc_mismatch);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_geometry_lock();
        open_frame(1);
        n_checks++;
        repeat (3) @(negedge clk);
        if (done_pulses !== 0) begin
            n_fail++; $display("FAIL first_edge pulses got %0d exp 0", done_pulses);
        end
        for (int f = 1; f <= 3; f++) run_frame($sformatf("sys86_f%0d", f), 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
    endtask

    task automatic test_relock();
        run_frame("short_f4", 24, 15, 4, 18, 2, 12, 5, 1, -1, -1, 0);
        run_frame("relock_f5", 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
        run_frame("relock_f6", 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
    endtask

    task automatic test_blank();
        run_frame("all_blank", 24, 16, 4, 18, 2, 0, 5, 2, -1, -1, 0);
    endtask

    task automatic test_crc_flip();
        run_frame("crc_a1", 24, 16, 4, 18, 2, 12, 9, 2, -1, -1, 0);
        run_frame("crc_a2", 24, 16, 4, 18, 2, 12, 9, 2, -1, -1, 0);
        run_frame("crc_flip", 24, 16, 4, 18, 2, 12, 9, 2, 7, 7, 7);
    endtask

    task automatic test_saturation();
        run_frame("h_sat", 4200, 4, 2, 5, 1, 2, 3, 0, -1, -1, 0);
    endtask

    task automatic test_random();
        int hl, vl, hx, aw, vy, ah;
        for (int f = 0; f < 4; f++) begin
            hl = $urandom_range(30, 8);
            vl = $urandom_range(14, 5);
            hx = $urandom_range(3, 1);
            aw = $urandom_range(hl - hx, 1);
            vy = $urandom_range(2, 1);
            ah = $urandom_range(vl - vy, 0);
            run_frame($sformatf("rand%0d", f), hl, vl, hx, aw, vy, ah, int'($urandom_range(999, 0)), 3, -1, -1, 0);
        end
    endtask

    task automatic test_midframe_reset();
        drive_body(24, 5, 4, 18, 2, 12, 5, 1, -1, -1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        have_prev = 0;
        run = 0;
        exp_fc = 0;
        repeat (2) @(negedge clk);
        pix_ce = 1'b0;
        rst_n = 1'b1;
        open_frame(1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_pulses !== exp_pulses || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_edge pulses got %0d exp %0d fc got %0d exp 0",
                     done_pulses, exp_pulses, frame_count);
        end
        run_frame("after_reset", 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
    endtask

`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
    task automatic test_crc_check();
        crc_expected = model_crc(4, 18, 2, 12, 5, -1, -1, 0);
        run_frame("chk_match", 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
        n_checks++;
        if (crc_mismatch !== 1'b0) begin
            n_fail++; $display("FAIL chk_match crc_mismatch got %b exp 0", crc_mismatch);
        end
        run_frame("chk_flip", 24, 16, 4, 18, 2, 12, 5, 1, 6, 4, 3);
        n_checks++;
        if (crc_mismatch !== 1'b1) begin
            n_fail++; $display("FAIL chk_flip crc_mismatch got %b exp 1", crc_mismatch);
        end
        run_frame("chk_sticky", 24, 16, 4, 18, 2, 12, 5, 1, -1, -1, 0);
        n_checks++;
        if (crc_mismatch !== 1'b1) begin
            n_fail++; $display("FAIL chk_sticky crc_mismatch got %b exp 1", crc_mismatch);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_geometry_lock();
        test_relock();
        test_blank();
        test_crc_flip();
        test_random();
        test_saturation();
        test_midframe_reset();
`ifdef VIDEO_FRAME_MONITOR_CRC_CHECK_EN
        test_crc_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
